// File: rtl/rackbus_pkg.sv
// Shared constants, types and helpers for the rack-bus command decoder.
// Frame = 8 sextets: header, six payload sextets, XOR checksum.
package rackbus_pkg;

  localparam int FRAME_LEN = 8;
  localparam int SEXTET_W = 6;
  localparam int PAYLOAD_W = 36;
  localparam int BEAT_W = $clog2(FRAME_LEN);
  localparam int CNT_W = 16;

  localparam logic [SEXTET_W-1:0] DEF_CMD_HEADER = 6'h2A;
  localparam logic [SEXTET_W-1:0] DEF_IDLE_HEADER = 6'h00;

  typedef logic [SEXTET_W-1:0] sextet_t;
  typedef logic [PAYLOAD_W-1:0] payload_t;
  typedef logic [CNT_W-1:0] count_t;

  typedef enum logic [1:0] {
    HUNT,
    RECV,
    CHECK
  } state_e;

  typedef enum logic [1:0] {
    K_CMD,
    K_IDLE,
    K_OTHER
  } kind_e;

  // XOR of the header and every payload sextet.
  function automatic sextet_t frame_xor(
    sextet_t hdr,
    payload_t pl
  );
    sextet_t x;
    x = hdr;
    for (int i = 0; i < PAYLOAD_W / SEXTET_W; i++)
      x ^= pl[i*SEXTET_W +: SEXTET_W];
    return x;
  endfunction

  // Increment that sticks at all-ones.
  function automatic count_t sat_inc(
    count_t v,
    logic en
  );
    return (en && v != '1) ? v + count_t'(1) : v;
  endfunction

endpackage

// File: rtl/rackbus_cmd_decode_if.sv
// AXI4-Stream style command bundle (valid/ready/data).
// master drives data and valid, slave drives ready.
interface rackbus_cmd_decode_if;
  import rackbus_pkg::*;

  payload_t tdata;
  logic tvalid;
  logic tready;

  modport master (
    output tdata,
    output tvalid,
    input tready
  );

  modport slave (
    input tdata,
    input tvalid,
    output tready
  );

endinterface

// File: rtl/rackbus_cmd_fifo.sv
// First-word-fall-through command FIFO, DEPTH entries (power of two).
// Writer must only assert wr_en when not full or popping.
module rackbus_cmd_fifo
  import rackbus_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input logic clk,
  input logic rst_n,
  input logic wr_en,
  input payload_t wr_data,
  output logic full,
  rackbus_cmd_decode_if.master m
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  payload_t mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [AW:0] cnt;
  logic rd_en;

  assign m.tvalid = (cnt != '0);
  assign full = (cnt == (AW+1)'(DEPTH));
  assign rd_en = m.tvalid && m.tready;
  assign m.tdata = m.tvalid ? mem[rp] : '0;

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wp] <= wr_data;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (wr_en) wp <= wp + AW'(1);
      if (rd_en) rp <= rp + AW'(1);
      unique case ({wr_en, rd_en})
        2'b10: cnt <= cnt + (AW+1)'(1);
        2'b01: cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/rackbus_cmd_decode.sv
// Rack-bus frame decoder: aligns on sync, checks XOR, queues commands.
// Error counters only exist when RACKBUS_ERRCNT_EN is defined.
module rackbus_cmd_decode
  import rackbus_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter logic [5:0] CMD_HEADER = DEF_CMD_HEADER,
  parameter logic [5:0] IDLE_HEADER = DEF_IDLE_HEADER
) (
  input logic rxclk,
  input logic rxclk_aresetn,
  input logic rxclk_sync_i,
  input logic [5:0] dat_i,
  output logic [35:0] cmd_tdata,
  output logic cmd_tvalid,
  input logic cmd_tready,
  output logic [15:0] chk_err_count_o,
  output logic [15:0] align_err_count_o,
  output logic [15:0] ovf_count_o,
  output logic locked_o
);

  localparam logic [BEAT_W-1:0] LAST_BEAT =
    BEAT_W'(FRAME_LEN - 1);

  logic [1:0] rst_sync;
  logic rst_n;
  state_e state;
  logic [BEAT_W-1:0] beat;
  sextet_t hdr;
  sextet_t csum;
  payload_t payload;
  logic good_seen;
  logic in_check;
  logic good;
  kind_e kind;
  logic push;
  logic pop;
  logic full;
  logic wr_en;

  rackbus_cmd_decode_if axis ();

  // Assert asynchronously, release on rxclk.
  always_ff @(posedge rxclk or negedge rxclk_aresetn) begin
    if (!rxclk_aresetn) rst_sync <= '0;
    else rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n = rst_sync[1];

  assign in_check = (state == CHECK);
  assign good = (frame_xor(hdr, payload) == csum);

  // Classify the captured header.
  always_comb begin
    kind = K_OTHER;
    unique case (1'b1)
      (hdr == CMD_HEADER): kind = K_CMD;
      (hdr == IDLE_HEADER): kind = K_IDLE;
      default: kind = K_OTHER;
    endcase
  end

  assign push = in_check && good && (kind == K_CMD);
  assign pop = axis.tvalid && axis.tready;
  assign wr_en = push && (!full || pop);

  // Frame alignment FSM with registered lock flag.
  always_ff @(posedge rxclk or negedge rst_n) begin
    if (!rst_n) begin
      state <= HUNT;
      beat <= '0;
      hdr <= '0;
      csum <= '0;
      payload <= '0;
      good_seen <= 1'b0;
      locked_o <= 1'b0;
    end else begin
      unique case (state)
        HUNT: begin
          if (rxclk_sync_i) begin
            hdr <= dat_i;
            beat <= BEAT_W'(1);
            state <= RECV;
          end
        end
        RECV: begin
          if (rxclk_sync_i && beat != LAST_BEAT) begin
            hdr <= dat_i;
            beat <= BEAT_W'(1);
            good_seen <= 1'b0;
            locked_o <= 1'b0;
          end else if (beat == LAST_BEAT) begin
            csum <= dat_i;
            state <= CHECK;
          end else begin
            payload <= {payload[PAYLOAD_W-SEXTET_W-1:0], dat_i};
            beat <= beat + BEAT_W'(1);
          end
        end
        CHECK: begin
          good_seen <= good;
          locked_o <= good && good_seen;
          if (rxclk_sync_i) begin
            hdr <= dat_i;
            beat <= BEAT_W'(1);
            state <= RECV;
          end else begin
            good_seen <= 1'b0;
            locked_o <= 1'b0;
            state <= HUNT;
          end
        end
        default: state <= HUNT;
      endcase
    end
  end

  rackbus_cmd_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk(rxclk),
    .rst_n(rst_n),
    .wr_en(wr_en),
    .wr_data(payload),
    .full(full),
    .m(axis)
  );

  assign axis.tready = cmd_tready;
  assign cmd_tdata = axis.tdata;
  assign cmd_tvalid = axis.tvalid;

`ifdef RACKBUS_ERRCNT_EN
  logic chk_ev;
  logic align_ev;
  logic ovf_ev;

  assign chk_ev = in_check && !good;
  assign align_ev =
    (state == RECV && rxclk_sync_i && beat != LAST_BEAT) ||
    (in_check && !rxclk_sync_i);
  assign ovf_ev = push && full && !pop;

  // Saturating error counters.
  always_ff @(posedge rxclk or negedge rst_n) begin
    if (!rst_n) begin
      chk_err_count_o <= '0;
      align_err_count_o <= '0;
      ovf_count_o <= '0;
    end else begin
      chk_err_count_o <= sat_inc(chk_err_count_o, chk_ev);
      align_err_count_o <= sat_inc(align_err_count_o, align_ev);
      ovf_count_o <= sat_inc(ovf_count_o, ovf_ev);
    end
  end
`else
  assign chk_err_count_o = '0;
  assign align_err_count_o = '0;
  assign ovf_count_o = '0;
`endif

endmodule

// File: tb/tb_rackbus_cmd_decode.sv
// Randomized bench for rackbus_cmd_decode against a beat-level
// frame model with a queue standing in for the command FIFO.
module tb_rackbus_cmd_decode;
  import rackbus_pkg::*;

  localparam int DEPTH = 4;
  localparam logic [5:0] CMD = 6'h2A;
  localparam logic [5:0] IDLE = 6'h00;
`ifdef RACKBUS_ERRCNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic sync_i;
  logic [5:0] dat;
  logic [15:0] chk_cnt;
  logic [15:0] align_cnt;
  logic [15:0] ovf_cnt;
  logic locked;

  rackbus_cmd_decode_if axis ();

  rackbus_cmd_decode #(
    .FIFO_DEPTH(DEPTH),
    .CMD_HEADER(CMD),
    .IDLE_HEADER(IDLE)
  ) dut (
    .rxclk(clk),
    .rxclk_aresetn(rst_n),
    .rxclk_sync_i(sync_i),
    .dat_i(dat),
    .cmd_tdata(axis.tdata),
    .cmd_tvalid(axis.tvalid),
    .cmd_tready(axis.tready),
    .chk_err_count_o(chk_cnt),
    .align_err_count_o(align_cnt),
    .ovf_count_o(ovf_cnt),
    .locked_o(locked)
  );

  int n_tests = 0;
  int n_fail = 0;

  logic [35:0] q[$];
  logic [5:0] m_beats[8];
  int m_pos;
  int m_run;
  bit m_locked;
  int e_chk;
  int e_align;
  int e_ovf;
  int rdy_mode;

  task automatic check_eq(
    input string tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] cexp(input int n);
    if (!CNT_EN) return 16'h0;
    return (n > 65535) ? 16'hFFFF : 16'(n);
  endfunction

  task automatic model_reset();
    q.delete();
    m_pos = -1;
    m_run = 0;
    m_locked = 1'b0;
    e_chk = 0;
    e_align = 0;
    e_ovf = 0;
  endtask

  task automatic lose_align();
    e_align++;
    m_run = 0;
    m_locked = 1'b0;
  endtask

  task automatic eval_frame();
    logic [5:0] x;
    logic [35:0] pl;
    x = m_beats[0];
    pl = '0;
    for (int i = 1; i <= 6; i++) begin
      x ^= m_beats[i];
      pl = {pl[29:0], m_beats[i]};
    end
    if (x == m_beats[7]) begin
      m_run++;
      m_locked = (m_run >= 2);
      if (m_beats[0] == CMD) begin
        if (q.size() < DEPTH) q.push_back(pl);
        else e_ovf++;
      end
    end else begin
      e_chk++;
      m_run = 0;
      m_locked = 1'b0;
    end
  endtask

  // m_pos: -1 hunting, 0..7 beat of this cycle, 8 = expecting beat 0
  task automatic model_step(
    input bit s,
    input logic [5:0] d,
    input bit rdy
  );
    if (rdy && q.size() != 0) void'(q.pop_front());
    if (m_pos == 8) begin
      eval_frame();
      if (!s) begin
        lose_align();
        m_pos = -1;
      end
    end else if (m_pos >= 1 && m_pos <= 6 && s) begin
      lose_align();
    end
    if (s && m_pos != 7) begin
      m_beats[0] = d;
      m_pos = 1;
    end else if (m_pos >= 1 && m_pos <= 7) begin
      m_beats[m_pos] = d;
      m_pos++;
    end
  endtask

  task automatic cycle(input bit s, input logic [5:0] d);
    bit rdy;
    check_eq("tvalid", 64'(axis.tvalid), 64'(q.size() != 0));
    if (q.size() != 0)
      check_eq("tdata", 64'(axis.tdata), 64'(q[0]));
    check_eq("locked", 64'(locked), 64'(m_locked));
    check_eq("chk_cnt", 64'(chk_cnt), 64'(cexp(e_chk)));
    check_eq("align_cnt", 64'(align_cnt), 64'(cexp(e_align)));
    check_eq("ovf_cnt", 64'(ovf_cnt), 64'(cexp(e_ovf)));
    if (rdy_mode == 0) rdy = 1'b0;
    else if (rdy_mode == 1) rdy = 1'b1;
    else rdy = ($urandom_range(0, 3) != 0);
    sync_i = s;
    dat = d;
    axis.tready = rdy;
    model_step(s, d, rdy);
    @(negedge clk);
  endtask

  task automatic send_body(
    input logic [5:0] hdr,
    input logic [35:0] pl,
    input logic [5:0] flip
  );
    logic [5:0] x;
    logic [5:0] s6;
    x = hdr;
    for (int i = 0; i < 6; i++) begin
      s6 = pl[35-6*i -: 6];
      x ^= s6;
      cycle(1'b0, s6);
    end
    cycle(1'b0, x ^ flip);
  endtask

  task automatic send_frame(
    input logic [5:0] hdr,
    input logic [35:0] pl,
    input logic [5:0] flip
  );
    cycle(1'b1, hdr);
    send_body(hdr, pl, flip);
  endtask

  task automatic send_trunc(input logic [5:0] hdr, input int k);
    cycle(1'b1, hdr);
    for (int i = 1; i < k; i++) cycle(1'b0, 6'($urandom));
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_tvalid"}, 64'(axis.tvalid), 64'd0);
    check_eq({tag, "_tdata"}, 64'(axis.tdata), 64'd0);
    check_eq({tag, "_locked"}, 64'(locked), 64'd0);
    check_eq({tag, "_chk"}, 64'(chk_cnt), 64'd0);
    check_eq({tag, "_align"}, 64'(align_cnt), 64'd0);
    check_eq({tag, "_ovf"}, 64'(ovf_cnt), 64'd0);
  endtask

  task automatic reset_now(input string tag);
    #2 rst_n = 1'b0;
    #1 check_zero(tag);
    sync_i = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) cycle(1'b0, 6'($urandom));
  endtask

  initial begin
    logic [5:0] h;
    logic [5:0] fl;
    logic [35:0] pl;
    int r;
    rst_n = 1'b0;
    sync_i = 1'b0;
    dat = '0;
    axis.tready = 1'b0;
    rdy_mode = 1;
    model_reset();
    repeat (3) @(negedge clk);
    check_zero("rst");
    rst_n = 1'b1;
    repeat (3) cycle(1'b0, 6'h15);

    // good command, then idle frame keeps alignment
    send_frame(CMD, 36'h123456789, 6'h00);
    cycle(1'b1, IDLE);
    check_eq("good_valid", 64'(axis.tvalid), 64'd1);
    check_eq("good_data", 64'(axis.tdata), 64'h123456789);
    check_eq("good_chk", 64'(chk_cnt), 64'd0);
    check_eq("good_align", 64'(align_cnt), 64'd0);
    check_eq("good_ovf", 64'(ovf_cnt), 64'd0);
    send_body(IDLE, 36'h0, 6'h00);

    // checksum bit 0 flipped
    send_frame(CMD, 36'h123456789, 6'h01);
    cycle(1'b1, IDLE);
    check_eq("bad_valid", 64'(axis.tvalid), 64'd0);
    check_eq("bad_chk", 64'(chk_cnt), 64'(CNT_EN));
    check_eq("bad_locked", 64'(locked), 64'd0);
    send_body(IDLE, 36'h0, 6'h00);

    // sync arriving at beat 4
    send_trunc(CMD, 4);
    cycle(1'b1, CMD);
    check_eq("mis_align", 64'(align_cnt), 64'(CNT_EN));
    send_body(CMD, 36'hABCDEF012, 6'h00);
    cycle(1'b1, IDLE);
    check_eq("mis_valid", 64'(axis.tvalid), 64'd1);
    check_eq("mis_data", 64'(axis.tdata), 64'hABCDEF012);
    send_body(IDLE, 36'h0, 6'h00);
    repeat (3) cycle(1'b0, 6'h3F);

    // five commands against a stalled consumer
    reset_now("rst2");
    rdy_mode = 0;
    for (int i = 1; i <= 5; i++)
      send_frame(CMD, 36'(36'h111111111 * i), 6'h00);
    cycle(1'b1, IDLE);
    check_eq("ovf_cnt1", 64'(ovf_cnt), 64'(CNT_EN));
    send_body(IDLE, 36'h0, 6'h00);
    repeat (3) cycle(1'b0, 6'h00);
    rdy_mode = 1;
    for (int i = 1; i <= 4; i++) begin
      check_eq("ovf_order", 64'(axis.tdata),
               64'(36'(36'h111111111 * i)));
      cycle(1'b0, 6'h00);
    end
    check_eq("ovf_empty", 64'(axis.tvalid), 64'd0);

    // reset in the middle of a frame
    rdy_mode = 0;
    send_frame(CMD, 36'hFEDCBA987, 6'h00);
    cycle(1'b1, CMD);
    cycle(1'b0, 6'h11);
    cycle(1'b0, 6'h22);
    sync_i = 1'b0;
    dat = 6'h33;
    reset_now("rst3");
    rdy_mode = 1;
    send_frame(CMD, 36'h0F0F0F0F0, 6'h00);
    cycle(1'b1, IDLE);
    check_eq("rr_valid", 64'(axis.tvalid), 64'd1);
    check_eq("rr_data", 64'(axis.tdata), 64'h0F0F0F0F0);
    check_eq("rr_chk", 64'(chk_cnt), 64'd0);
    check_eq("rr_align", 64'(align_cnt), 64'd0);
    check_eq("rr_ovf", 64'(ovf_cnt), 64'd0);
    send_body(IDLE, 36'h0, 6'h00);

    // randomized frame stream
    for (int f = 0; f < 300; f++) begin
      rdy_mode = ((f % 50) < 10) ? 0 : 2;
      r = $urandom_range(0, 99);
      if (r < 60) h = CMD;
      else if (r < 75) h = IDLE;
      else h = 6'($urandom);
      pl = 36'({$urandom, $urandom});
      fl = ($urandom_range(0, 7) == 0) ?
           6'($urandom_range(1, 63)) : 6'h00;
      if ($urandom_range(0, 9) == 0)
        send_trunc(h, $urandom_range(1, 6));
      else
        send_frame(h, pl, fl);
      if ($urandom_range(0, 9) == 0)
        repeat ($urandom_range(1, 4)) cycle(1'b0, 6'($urandom));
    end

    rdy_mode = 1;
    repeat (10) cycle(1'b0, 6'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rackbus_cmd_decode.md
RACKBUS_CMD_DECODE -- requirements
Module: rackbus_cmd_decode

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, output FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter CMD_HEADER, default 6'h2A, header sextet marking a command frame.
REQ-003 SHALL have parameter IDLE_HEADER, default 6'h00, header sextet marking an idle frame.
REQ-004 SHALL have port rxclk  input  1  sole clock, the recovered rack-bus clock.
REQ-005 SHALL have port rxclk_aresetn  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port rxclk_sync_i  input  1  one-cycle pulse marking beat 0 of every 8-beat frame.
REQ-007 SHALL have port dat_i  input  6  deserialized rack-bus sextet, one per rxclk.
REQ-008 SHALL have port cmd_tdata  output  36  decoded command payload; beat 1 in bits [35:30], beat 6 in bits [5:0].
REQ-009 SHALL have port cmd_tvalid  output  1  AXI4-Stream valid.
REQ-010 SHALL have port cmd_tready  input  1  AXI4-Stream ready.
REQ-011 SHALL have port chk_err_count_o  output  16  saturating checksum-error count.
REQ-012 SHALL have port align_err_count_o  output  16  saturating misaligned-sync count.
REQ-013 SHALL have port ovf_count_o  output  16  saturating dropped-command count.
REQ-014 SHALL have port locked_o  output  1  high while frames arrive aligned.

Function
REQ-015 SHALL run an FSM with states HUNT, RECV, CHECK.
REQ-016 In HUNT, rxclk_sync_i high SHALL capture dat_i as the header, clear the beat counter to 1, and enter RECV.
REQ-017 In RECV, beats 1..6 SHALL shift into the payload register; beat 7 SHALL be captured as the checksum and the FSM SHALL enter CHECK.
REQ-018 Checksum SHALL be the XOR of the header and all six payload sextets; a frame is good when it equals the beat-7 sextet.
REQ-019 CHECK SHALL last one cycle and then enter RECV on beat 0 of the next frame, capturing its header.
REQ-020 The cycle after CHECK SHALL coincide with rxclk_sync_i; if sync is absent there, the FSM SHALL increment align_err_count_o, clear locked_o and enter HUNT.
REQ-021 rxclk_sync_i high in RECV before beat 7 SHALL discard the partial frame, increment align_err_count_o, treat the cycle as beat 0 of a new frame, and clear locked_o.
REQ-022 A good frame with header CMD_HEADER SHALL push its payload into the FIFO in the CHECK cycle.
REQ-023 A good frame with header IDLE_HEADER SHALL be discarded silently.
REQ-024 A good frame with any other header SHALL be discarded silently.
REQ-025 A bad checksum SHALL increment chk_err_count_o and push nothing.
REQ-026 locked_o SHALL set after two consecutive good frames and SHALL clear on any checksum or alignment error.
REQ-027 A push into a full FIFO SHALL drop the new command, keep the FIFO contents, and increment ovf_count_o.
REQ-028 A simultaneous push and pop on a full FIFO SHALL succeed with no overflow.
REQ-029 cmd_tvalid SHALL be high exactly when the FIFO is non-empty; a pop occurs when cmd_tvalid and cmd_tready are both high.
REQ-030 cmd_tdata SHALL be stable while cmd_tvalid is high and cmd_tready is low.
REQ-031 Latency SHALL be 1 cycle from the beat-7 sample to cmd_tvalid rising on an empty FIFO.
REQ-032 All counters SHALL saturate at 16'hFFFF.

Reset
REQ-033 Reset low SHALL asynchronously force: FSM to HUNT, FIFO empty, cmd_tvalid 0, cmd_tdata 0, all counters 0, locked_o 0.
REQ-034 Release of reset SHALL be synchronous to rxclk.
REQ-035 A frame in progress at reset assertion SHALL be lost and SHALL NOT be counted.

Configuration
REQ-036 With RACKBUS_ERRCNT_EN defined, the three counters of REQ-011 to REQ-013 SHALL be implemented.
REQ-037 Without RACKBUS_ERRCNT_EN, the three counter outputs SHALL be tied to 0 with no counter logic; all other behaviour SHALL be unchanged.

Structure
REQ-038 A shared package rackbus_pkg SHALL hold the frame-length constant (8), the sextet width (6), the payload width (36), the default header values, and the FSM state enum.
REQ-039 The FIFO SHALL be a sub-module rackbus_cmd_fifo (synchronous, first-word-fall-through, FIFO_DEPTH entries, 36 bits wide).

Verification
REQ-040 Scenario: aligned good command frame, header 2A, payload 123456789, cmd_tready=1 -> cmd_tdata=36'h123456789 valid 1 cycle after beat 7, counters 0.
REQ-041 Scenario: same frame with bit 0 of the checksum flipped -> no cmd_tvalid, chk_err_count_o=1, locked_o=0.
REQ-042 Scenario: rxclk_sync_i pulse at beat 4 -> align_err_count_o=1, then the next full frame decodes correctly.
REQ-043 Scenario: cmd_tready=0, 5 good commands, FIFO_DEPTH=4 -> first 4 held in order, ovf_count_o=1, stable tdata.
REQ-044 Scenario: reset asserted at beat 3 of a frame -> all outputs 0 immediately, next aligned frame decodes, no errors counted.
REQ-045 Scenario: build without RACKBUS_ERRCNT_EN plus a bad-checksum frame -> chk_err_count_o stays 0, frame dropped.
